// File: rtl/score_sequencer.sv
// Score increment sequencer: turns pipe-pass levels into spaced, queued increment
// pulses for the BCD digit chain and keeps a BCD mirror of the displayed score.
module score_sequencer #(
   parameter  int unsigned MAX_PENDING = 7,
   parameter  int unsigned GAP_CYCLES  = 2,
   parameter  int unsigned MAX_SCORE   = 99,
   localparam int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pass_in,
   input  logic          game_over,
   input  logic          new_game,
   output logic          incr_out,
   output logic          digit_clr,
   output logic [PW-1:0] pending,
   output logic [3:0]    score_tens,
   output logic [3:0]    score_ones,
   output logic          saturated,
   output logic          overflow,
   output logic          busy
);

   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ISSUE, S_GAP, S_FROZEN} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pend_q, pend_d, pend_nx;
   logic [3:0]    tens_q, tens_d, ones_q, ones_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          ovf_q, ovf_d;
   logic          pass_q;
   logic          incr_q, clr_q, busy_q;
   logic          live, evt, at_ceiling, q_full, accept, issuing;
   logic [15:0]   mirror_bin, committed;

   assign evt        = pass_in & ~pass_q;
   assign live       = ((state_q == S_IDLE) || (state_q == S_ISSUE) || (state_q == S_GAP)) && !game_over;
   assign mirror_bin = 16'(tens_q) * 16'd10 + 16'(ones_q);
   assign committed  = mirror_bin + 16'(pend_q);
   assign at_ceiling = committed >= 16'(MAX_SCORE);
   assign q_full     = 32'(pend_q) >= MAX_PENDING;
   assign accept     = live & evt & ~at_ceiling & ~q_full;
   assign issuing    = (state_q == S_ISSUE);

   always_comb begin
      pend_nx = pend_q;
      if (accept && !issuing)      pend_nx = pend_q + PW'(1);
      else if (!accept && issuing) pend_nx = pend_q - PW'(1);

      state_d = state_q;
      pend_d  = pend_nx;
      tens_d  = tens_q;
      ones_d  = ones_q;
      gap_d   = gap_q;
      ovf_d   = ovf_q | (live & evt & ~at_ceiling & q_full);

      case (state_q)
         S_CLEAR: begin
            state_d = game_over ? S_FROZEN : S_IDLE;
            pend_d  = '0;
            tens_d  = '0;
            ones_d  = '0;
            ovf_d   = 1'b0;
         end
         S_IDLE: if (pend_nx != '0) state_d = S_ISSUE;
         S_ISSUE: begin
            if (ones_q == 4'd9) begin
               ones_d = '0;
               tens_d = tens_q + 4'd1;
            end else begin
               ones_d = ones_q + 4'd1;
            end
            gap_d   = GW'(GAP_CYCLES);
            state_d = S_GAP;
         end
         // Last gap cycle makes the IDLE decision itself so pulses land exactly 1+GAP_CYCLES apart.
         S_GAP: begin
            gap_d = gap_q - GW'(1);
            if (gap_q == GW'(1)) state_d = (pend_nx != '0) ? S_ISSUE : S_IDLE;
         end
         S_FROZEN: state_d = S_FROZEN;
         default:  state_d = S_CLEAR;
      endcase

      if (game_over && (state_q inside {S_IDLE, S_ISSUE, S_GAP})) begin
         state_d = S_FROZEN;
         pend_d  = '0;
      end

      if (new_game) begin
         state_d = S_CLEAR;
         pend_d  = '0;
         tens_d  = '0;
         ones_d  = '0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_CLEAR;
         pend_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         gap_q   <= '0;
         ovf_q   <= 1'b0;
         pass_q  <= 1'b0;
         incr_q  <= 1'b0;
         clr_q   <= 1'b1;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         gap_q   <= gap_d;
         ovf_q   <= ovf_d;
         pass_q  <= pass_in;
         incr_q  <= (state_d == S_ISSUE);
         clr_q   <= (state_d == S_CLEAR);
         busy_q  <= (state_d inside {S_ISSUE, S_GAP, S_CLEAR}) || (pend_d != '0);
      end
   end

   assign incr_out   = incr_q;
   assign digit_clr  = clr_q;
   assign pending    = pend_q;
   assign score_tens = tens_q;
   assign score_ones = ones_q;
   assign saturated  = (mirror_bin == 16'(MAX_SCORE));
   assign overflow   = ovf_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: time-based behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_score_sequencer;

   localparam int MAXP = 7;
   localparam int GAP  = 2;
   localparam int MAXS = 99;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pass_in = 1'b0;
   logic       game_over = 1'b0;
   logic       new_game = 1'b0;
   logic       incr_out, digit_clr, saturated, overflow, busy;
   logic [2:0] pending;
   logic [3:0] score_tens, score_ones;

   int checks = 0;
   int errors = 0;
   int npulse = 0;
   int cyc_no = 0;
   int pk     = 0;
   int ptimes[$];

   always #5 clk = ~clk;

   score_sequencer #(.MAX_PENDING(MAXP), .GAP_CYCLES(GAP), .MAX_SCORE(MAXS)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .pass_in   (pass_in),
      .game_over (game_over),
      .new_game  (new_game),
      .incr_out  (incr_out),
      .digit_clr (digit_clr),
      .pending   (pending),
      .score_tens(score_tens),
      .score_ones(score_ones),
      .saturated (saturated),
      .overflow  (overflow),
      .busy      (busy)
   );

   // Model: score as an integer, a pending count, and pulse timing by cycle index.
   typedef enum {M_CLR, M_RUN, M_FRZ} mmode_t;
   mmode_t m_mode  = M_CLR;
   int     m_pend  = 0;
   int     m_mir   = 0;
   int     m_cyc   = 0;
   int     m_last  = -1000;
   bit     m_ovf   = 1'b0;
   bit     m_pulse = 1'b0;
   bit     m_prev  = 1'b0;

   always @(posedge clk) m_cyc <= m_cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      mmode_t mode;
      int     pend, mir, last, used;
      bit     ovf, pulse, ev;
      if (!rst_n) begin
         m_mode  <= M_CLR;
         m_pend  <= 0;
         m_mir   <= 0;
         m_ovf   <= 1'b0;
         m_pulse <= 1'b0;
         m_prev  <= 1'b0;
         m_last  <= -1000;
      end else begin
         mode  = m_mode;
         pend  = m_pend;
         mir   = m_mir;
         last  = m_last;
         ovf   = m_ovf;
         pulse = m_pulse;
         ev    = pass_in && !m_prev;
         used  = m_mir + m_pend;
         if (m_pulse) last = m_cyc;
         if (new_game) begin
            mode = M_CLR; pend = 0; mir = 0; ovf = 1'b0; pulse = 1'b0; last = -1000;
         end else if (m_mode == M_CLR) begin
            mode  = game_over ? M_FRZ : M_RUN;
            pulse = 1'b0;
         end else if (m_mode == M_FRZ) begin
            pulse = 1'b0;
         end else begin
            if (m_pulse) mir = mir + 1;
            if (game_over) begin
               mode = M_FRZ; pend = 0; pulse = 1'b0;
            end else begin
               if (ev) begin
                  if (used >= MAXS) ;
                  else if (m_pend >= MAXP) ovf = 1'b1;
                  else pend = pend + 1;
               end
               if (m_pulse) pend = pend - 1;
               pulse = (pend > 0) && ((m_cyc + 1 - last) >= 1 + GAP);
            end
         end
         m_mode  <= mode;
         m_pend  <= pend;
         m_mir   <= mir;
         m_ovf   <= ovf;
         m_pulse <= pulse;
         m_last  <= last;
         m_prev  <= pass_in;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every wait goes through here: one negedge sample per cycle, compared to the model.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc_no++;
         if (incr_out) begin
            npulse++;
            ptimes.push_back(cyc_no);
         end
         if (int'(pending) > pk) pk = int'(pending);
         check("m_incr_out",  incr_out,   m_pulse);
         check("m_digit_clr", digit_clr,  m_mode == M_CLR);
         check("m_pending",   pending,    m_pend);
         check("m_tens",      score_tens, m_mir / 10);
         check("m_ones",      score_ones, m_mir % 10);
         check("m_saturated", saturated,  m_mir == MAXS);
         check("m_overflow",  overflow,   m_ovf);
         check("m_busy",      busy, (m_mode == M_CLR) || m_pulse ||
                                    (m_mode == M_RUN && (m_cyc - m_last) <= GAP) || (m_pend != 0));
      end
   endtask

   task automatic rise(input int hi, input int lo);
      pass_in = 1'b1;
      tick(hi);
      pass_in = 1'b0;
      tick(lo);
   endtask

   initial begin
      int base;
      int n;

      // Reset and release
      tick(3);
      check("rst_digit_clr", digit_clr, 1);
      check("rst_busy", busy, 1);
      check("rst_incr", incr_out, 0);
      check("rst_saturated", saturated, 0);
      #2 rst_n = 1'b1;
      #1 check("release_clr_cycle", digit_clr, 1);
      tick(1);
      check("idle_clr", digit_clr, 0);
      check("idle_busy", busy, 0);
      check("idle_score", score_tens * 10 + score_ones, 0);

      // Single rise held 5 cycles
      pass_in = 1'b1;
      tick(1);
      check("single_pulse", incr_out, 1);
      check("single_pending", pending, 1);
      tick(1);
      check("single_pulse_end", incr_out, 0);
      check("single_score", score_ones, 1);
      check("single_pend0", pending, 0);
      tick(3);
      pass_in = 1'b0;
      tick(6);
      check("single_count", npulse, 1);

      // Four rises on alternate cycles
      pk = 0;
      base = npulse;
      repeat (4) rise(1, 1);
      tick(12);
      check("burst_count", npulse - base, 4);
      n = ptimes.size();
      for (int i = n - 3; i < n; i++) check("burst_spacing", ptimes[i] - ptimes[i - 1], 3);
      check("burst_peak_pending", pk, 2);
      check("burst_score", score_tens * 10 + score_ones, 5);

      // BCD wrap 09 -> 10
      repeat (4) rise(1, 3);
      tick(6);
      check("wrap_pre_ones", score_ones, 9);
      check("wrap_pre_tens", score_tens, 0);
      rise(1, 3);
      tick(6);
      check("wrap_tens", score_tens, 1);
      check("wrap_ones", score_ones, 0);

      // Climb to 98, then two rises at the ceiling
      repeat (88) rise(1, 3);
      tick(6);
      check("pre98_tens", score_tens, 9);
      check("pre98_ones", score_ones, 8);
      check("pre98_sat", saturated, 0);
      base = npulse;
      rise(1, 1);
      rise(1, 1);
      tick(10);
      check("ceil_pulses", npulse - base, 1);
      check("ceil_ones", score_ones, 9);
      check("ceil_sat", saturated, 1);
      check("ceil_overflow", overflow, 0);

      // New game, then overfill the queue
      new_game = 1'b1;
      tick(1);
      new_game = 1'b0;
      check("ng_clr", digit_clr, 1);
      check("ng_score", score_tens * 10 + score_ones, 0);
      check("ng_sat", saturated, 0);
      tick(1);
      check("ng_clr_end", digit_clr, 0);
      pk = 0;
      repeat (30) rise(1, 1);
      check("full_overflow", overflow, 1);
      check("full_peak", pk, 7);
      game_over = 1'b1;
      tick(2);
      check("frz_pending", pending, 0);
      base = npulse;
      tick(10);
      check("frz_no_pulse", npulse - base, 0);
      check("frz_busy", busy, 0);
      check("frz_overflow", overflow, 1);
      game_over = 1'b0;
      tick(2);
      new_game = 1'b1;
      tick(1);
      new_game = 1'b0;
      check("ng2_clr", digit_clr, 1);
      check("ng2_score", score_tens * 10 + score_ones, 0);
      check("ng2_overflow", overflow, 0);
      tick(1);
      check("ng2_clr_end", digit_clr, 0);

      // Level held high across CLEAR does not count
      base = npulse;
      pass_in = 1'b1;
      new_game = 1'b1;
      tick(1);
      new_game = 1'b0;
      tick(6);
      check("held_no_pulse", npulse - base, 0);
      pass_in = 1'b0;
      tick(1);
      rise(1, 6);
      check("held_then_rise", score_tens * 10 + score_ones, 1);

      // Reset in the middle of a burst
      repeat (5) rise(1, 1);
      #2 rst_n = 1'b0;
      tick(1);
      check("midrst_pending", pending, 0);
      check("midrst_score", score_tens * 10 + score_ones, 0);
      check("midrst_clr", digit_clr, 1);
      #2 rst_n = 1'b1;
      #1 check("midrst_release_clr", digit_clr, 1);
      base = npulse;
      tick(1);
      check("midrst_clr_end", digit_clr, 0);
      tick(6);
      check("midrst_no_pulse", npulse - base, 0);

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
